// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// A start/done handshake frames each conversion; the result and overflow flag are held between conversions.
module binary_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [SW-1:0]    r_scratch;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf_acc;
  logic [SW-1:0]    r_bcd;
  logic             r_ovf;
  logic             r_done;
  logic             r_busy;

  logic [SW-1:0]    w_adj;
  logic [SW-1:0]    w_next_scratch;
  logic             w_carry;
  logic             w_last;

  // A digit of 5..9 becomes 8..12, so it carries into the next digit when shifted.
  function automatic logic [3:0] f_add3(input logic [3:0] d);
    if (d >= 4'd5) begin
      return d + 4'd3;
    end else begin
      return d;
    end
  endfunction

  // Per-digit correction followed by the one-bit left shift of {scratch, operand}.
  always_comb begin
    w_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_adj[4*i +: 4] = f_add3(r_scratch[4*i +: 4]);
    end
    w_next_scratch = {w_adj[SW-2:0], r_shift[WIDTH-1]};
    w_carry        = w_adj[SW-1];
    w_last         = (r_cnt == CW'(1));
  end

  // Control FSM, datapath registers and held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift   <= bin;
            r_scratch <= '0;
            r_cnt     <= CW'(WIDTH);
            r_ovf_acc <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_scratch <= w_next_scratch;
          r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
          r_ovf_acc <= r_ovf_acc | w_carry;
          r_cnt     <= r_cnt - CW'(1);
          if (w_last) begin
            // A carry dropped off the top digit means the value needs more digits than we have.
            r_bcd   <= w_next_scratch;
            r_ovf   <= r_ovf_acc | w_carry;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_SHIFT;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed bench for binary_to_bcd_seq: three configurations (8/3, 8/2, 16/5) sharing one clock and reset.
module tb_binary_to_bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        s8, s2, s16;
  logic [7:0]  b8, b2;
  logic [15:0] b16;
  logic        busy8, done8, ovf8;
  logic [11:0] bcd8;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;
  logic        busy16, done16, ovf16;
  logic [19:0] bcd16;

  int n_vec = 0;
  int n_err = 0;

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk(clk), .reset(reset), .start(s8), .bin(b8),
    .busy(busy8), .done(done8), .bcd(bcd8), .overflow(ovf8));

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(s2), .bin(b2),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2));

  binary_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut16 (
    .clk(clk), .reset(reset), .start(s16), .bin(b16),
    .busy(busy16), .done(done16), .bcd(bcd16), .overflow(ovf16));

  function automatic logic [11:0] gold3(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic run8(input logic [7:0] v, output logic [11:0] r, output logic o,
                      output int lat, output int bcnt, output logic bz);
    @(negedge clk); s8 = 1'b1; b8 = v;
    @(negedge clk); s8 = 1'b0; b8 = ~v;
    lat = 0; bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      @(negedge clk); lat++;
    end
    r = bcd8; o = ovf8; bz = busy8;
  endtask

  task automatic run2(input logic [7:0] v, output logic [7:0] r, output logic o, output int lat);
    @(negedge clk); s2 = 1'b1; b2 = v;
    @(negedge clk); s2 = 1'b0; b2 = 8'h00;
    lat = 0;
    while (!done2 && lat < 40) begin @(negedge clk); lat++; end
    r = bcd2; o = ovf2;
  endtask

  task automatic run16(input logic [15:0] v, output logic [19:0] r, output logic o, output int lat);
    @(negedge clk); s16 = 1'b1; b16 = v;
    @(negedge clk); s16 = 1'b0; b16 = 16'h0000;
    lat = 0;
    while (!done16 && lat < 60) begin @(negedge clk); lat++; end
    r = bcd16; o = ovf16;
  endtask

  task automatic test_reset;
    reset = 1'b1; s8 = 1'b0; s2 = 1'b0; s16 = 1'b0;
    b8 = 8'h00; b2 = 8'h00; b16 = 16'h0000;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy8, done8, bcd8, ovf8} !== 15'd0) begin
      n_err++;
      $display("FAIL reset8: busy=%b done=%b bcd=%h ovf=%b, want all 0", busy8, done8, bcd8, ovf8);
    end
    n_vec++;
    if ({busy16, done16, bcd16, ovf16} !== 23'd0 || {busy2, done2, bcd2, ovf2} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_other: bcd16=%h bcd2=%h, want 0", bcd16, bcd2);
    end
    reset = 1'b0;
  endtask

  task automatic test_latency_255;
    logic [11:0] r; logic o, bz; int lat, bcnt;
    run8(8'd255, r, o, lat, bcnt, bz);
    n_vec++;
    if (lat !== 8) begin n_err++; $display("FAIL lat255: latency=%0d want 8", lat); end
    n_vec++;
    if (r !== 12'h255 || o !== 1'b0) begin
      n_err++; $display("FAIL conv255: bcd=%h ovf=%b want 255/0", r, o);
    end
    n_vec++;
    if (bcnt !== 8 || bz !== 1'b0) begin
      n_err++; $display("FAIL busy255: busy cycles=%0d busy_at_done=%b want 8/0", bcnt, bz);
    end
  endtask

  task automatic test_directed;
    logic [7:0]  vals [6] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd128};
    logic [11:0] exps [6] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h128};
    logic [11:0] r; logic o, bz; int lat, bcnt;
    for (int i = 0; i < 6; i++) begin
      run8(vals[i], r, o, lat, bcnt, bz);
      n_vec++;
      if (r !== exps[i] || o !== 1'b0 || lat !== 8) begin
        n_err++;
        $display("FAIL dir_%0d: bcd=%h ovf=%b lat=%0d want %h/0/8", vals[i], r, o, lat, exps[i]);
      end
    end
  endtask

  task automatic test_sweep;
    logic [11:0] r; logic o, bz; int lat, bcnt;
    for (int v = 0; v < 256; v++) begin
      run8(8'(v), r, o, lat, bcnt, bz);
      n_vec++;
      if (r !== gold3(v) || o !== 1'b0 || lat !== 8) begin
        n_err++;
        $display("FAIL sweep_%0d: bcd=%h ovf=%b lat=%0d want %h/0/8", v, r, o, lat, gold3(v));
      end
    end
  endtask

  task automatic test_digits2;
    logic [7:0] vals [3] = '{8'd255, 8'd99, 8'd100};
    logic [7:0] exps [3] = '{8'h55, 8'h99, 8'h00};
    logic       eovf [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] r; logic o; int lat;
    for (int i = 0; i < 3; i++) begin
      run2(vals[i], r, o, lat);
      n_vec++;
      if (r !== exps[i] || o !== eovf[i] || lat !== 8) begin
        n_err++;
        $display("FAIL d2_%0d: bcd=%h ovf=%b lat=%0d want %h/%b/8", vals[i], r, o, lat, exps[i], eovf[i]);
      end
    end
  endtask

  task automatic test_wide;
    logic [19:0] r; logic o; int lat;
    run16(16'hFFFF, r, o, lat);
    n_vec++;
    if (r !== 20'h65535 || o !== 1'b0 || lat !== 16) begin
      n_err++; $display("FAIL w16_ffff: bcd=%h ovf=%b lat=%0d want 65535/0/16", r, o, lat);
    end
    run16(16'd10000, r, o, lat);
    n_vec++;
    if (r !== 20'h10000 || o !== 1'b0 || lat !== 16) begin
      n_err++; $display("FAIL w16_10000: bcd=%h ovf=%b lat=%0d want 10000/0/16", r, o, lat);
    end
  endtask

  task automatic test_ignore_busy;
    int n, ndone;
    @(negedge clk); s8 = 1'b1; b8 = 8'd42;
    @(negedge clk); s8 = 1'b0;
    @(negedge clk); s8 = 1'b1; b8 = 8'd7;
    @(negedge clk); s8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    n_vec++;
    if (bcd8 !== 12'h042 || !done8) begin
      n_err++; $display("FAIL ignore_busy: bcd=%h done=%b want 042/1", bcd8, done8);
    end
    ndone = 0;
    repeat (12) begin @(negedge clk); if (done8) ndone++; end
    n_vec++;
    if (ndone !== 0) begin n_err++; $display("FAIL ignore_extra_done: dones=%0d want 0", ndone); end
  endtask

  task automatic test_back_to_back;
    int cyc, k, last;
    logic unstable;
    logic [11:0] held, want;
    @(negedge clk); s8 = 1'b1; b8 = 8'd42;
    cyc = 0; k = 0; last = 0; unstable = 1'b0; held = 12'h000;
    while (k < 4 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (done8) begin
        want = (k % 2 == 0) ? 12'h042 : 12'h007;
        n_vec++;
        if (bcd8 !== want) begin
          n_err++; $display("FAIL b2b_val_%0d: bcd=%h want %h", k, bcd8, want);
        end
        if (k > 0) begin
          n_vec++;
          if (cyc - last !== 9) begin
            n_err++; $display("FAIL b2b_period_%0d: period=%0d want 9", k, cyc - last);
          end
        end
        last = cyc; held = bcd8; k++;
        b8 = (k % 2 == 0) ? 8'd42 : 8'd7;
      end else if (k > 0 && bcd8 !== held) begin
        unstable = 1'b1;
      end
    end
    s8 = 1'b0;
    n_vec++;
    if (k !== 4) begin n_err++; $display("FAIL b2b_count: dones=%0d want 4", k); end
    n_vec++;
    if (unstable) begin n_err++; $display("FAIL b2b_hold: bcd changed between done pulses, want stable"); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [11:0] r; logic o, bz; int lat, bcnt, ndone;
    run8(8'd255, r, o, lat, bcnt, bz);
    @(negedge clk); s8 = 1'b1; b8 = 8'd200;
    @(negedge clk); s8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy8, done8, bcd8, ovf8} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b bcd=%h ovf=%b want all 0", busy8, done8, bcd8, ovf8);
    end
    reset = 1'b0;
    ndone = 0;
    repeat (12) begin @(negedge clk); if (done8) ndone++; end
    n_vec++;
    if (ndone !== 0) begin n_err++; $display("FAIL reset_no_done: dones=%0d want 0", ndone); end
    run8(8'd200, r, o, lat, bcnt, bz);
    n_vec++;
    if (r !== 12'h200 || o !== 1'b0 || lat !== 8) begin
      n_err++; $display("FAIL after_reset: bcd=%h ovf=%b lat=%0d want 200/0/8", r, o, lat);
    end
  endtask

  initial begin
    test_reset();
    test_latency_255();
    test_directed();
    test_sweep();
    test_digits2();
    test_wide();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_seq.md
# binary_to_bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It processes one input bit per clock. It replaces the fixed 8-bit, 3-digit combinational converter on paths where wider sensor values feed the 7-segment display formatter: heart-rate, SpO2, temperature × 10, and step counts. It provides a start/done handshake, a held result register and an overflow flag for values that do not fit in the configured digit count.

## Interface

Parameters:
- WIDTH, 8, binary input width in bits; legal range 4 to 32.
- DIGITS, 3, number of BCD digits produced; legal range 1 to 10.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  reset; synchronous, active-high.
- start  input  1  request a conversion; sampled only in IDLE.
- bin  input  WIDTH  unsigned binary operand; captured on the accepting edge, need not be held afterwards.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd and overflow are valid from this cycle.
- bcd  output  4*DIGITS  result; digit i occupies bits [4i+3:4i], and digit 0 is the ones digit.
- overflow  output  1  high when the last converted value was ≥ 10^DIGITS.

## Operation

- States: IDLE and SHIFT.
- IDLE:
  - When start=1, capture bin into the shift register, clear the DIGITS×4-bit scratch register, load the bit counter with WIDTH, clear the internal overflow accumulator, and go to SHIFT.
  - When start=0, hold all state.
- SHIFT, on every edge:
  - For each digit of the scratch register, if the digit is ≥ 5, add 3.
  - Then shift {scratch, operand} left by one, bringing in operand MSB as the scratch LSB.
  - If the bit shifted out of the scratch MSB is 1, set the overflow accumulator.
  - Decrement the counter.
- The last SHIFT edge is the one where the counter goes from 1 to 0. On that edge:
  - Load bcd with the shifted scratch value and overflow with the final accumulator value.
  - Assert done for the following cycle.
  - Return to IDLE.
- Arithmetic: the add-3 correction is computed per digit in 4 bits, and the result never exceeds 12 before the shift.
- Overflow behaviour: dropped carries preserve the value modulo 10^DIGITS. On overflow, bcd holds exactly the low DIGITS decimal digits of bin, and each digit is still ≤ 9.
- bcd and overflow are held unchanged between done pulses. They are not modified during a subsequent conversion until its own final edge.
- start while busy=1 is ignored; there is no queueing.
- Back-to-back operation: start asserted in the done cycle is accepted, because the FSM is already in IDLE.
- Reset (any state, including mid-conversion):
  - State goes to IDLE, and busy=0, done=0, bcd=0, overflow=0.
  - The aborted conversion produces no done pulse.

## Timing

- Accepting edge: call it E0, where start=1 and the FSM is in IDLE.
- busy goes 1 in the cycle after E0.
- Shift edges are E1 to E_WIDTH.
- done=1 and busy=0 in the cycle after E_WIDTH. Latency from the accepting edge to done is WIDTH cycles.
- Throughput is one conversion per WIDTH+1 cycles when start is held high.
- done is high for exactly one cycle per completed conversion.
- Reset values: busy=0, done=0, bcd=0, overflow=0.
- Critical path: one 4-bit compare-and-add per digit in parallel, plus the shift. It is independent of WIDTH and DIGITS.

## Test plan

- WIDTH=8, DIGITS=3, bin=8'd255, single start pulse:
  - done appears 8 cycles after the accepting edge.
  - bcd=12'h255, overflow=0.
  - busy is high for exactly 8 cycles.
- WIDTH=8, DIGITS=3, bin values 0, 9, 10, 99, 100, 128 and then an exhaustive sweep of 0 to 255 against a golden decimal model:
  - bcd equals the decimal digits in every case, e.g. 100 → 12'h100 and 0 → 12'h000.
  - overflow is always 0.
- WIDTH=8, DIGITS=2:
  - bin=255 → bcd=8'h55, overflow=1.
  - bin=99 → bcd=8'h99, overflow=0.
  - bin=100 → bcd=8'h00, overflow=1.
- WIDTH=16, DIGITS=5:
  - bin=16'hFFFF → bcd=20'h65535 after 16 cycles.
  - bin=16'd10000 → bcd=20'h10000.
- Handshake and hold behaviour:
  - Start at bin=42, then pulse start with bin=7 during busy. The second request is ignored and the result is bcd=042.
  - Hold start high with bin alternating 42 and 7 per accept. done pulses every 9 cycles, and results alternate 042 and 007.
  - bcd is stable between done pulses.
- Reset mid-conversion:
  - After a completed conversion of 255, start bin=200 and assert reset on the 4th shift cycle.
  - Next cycle: busy=0, bcd=0, overflow=0, and no done pulse.
  - A subsequent start with bin=200 yields bcd=12'h200.
